intersection_ctrl_n: RTL and testbench
======================================

Name: intersection_ctrl_n

Overview:
- Parametrised N-approach traffic-intersection controller. It is the successor to the fixed four-approach controller and its per-approach light modules.
- A single round-robin FSM serves approaches in index order 0..N-1.
- Per-approach green times are runtime inputs. An approach with a zero green time is skipped.
- Pedestrian requests are latched per approach and served in a dedicated all-vehicle-red walk phase. A service mode flashes every vehicle yellow.
- Sits at the top of the intersection design and drives the lamp outputs directly.

Parameters:
- N_APPR, 4, number of approaches; legal range 2..8.
- CLK_DIV, 1000, clk cycles per 1-second tick; must be >= 2.
- GREEN_W, 8, bit width of each green-time field, in seconds.
- YELLOW_S, 3, yellow duration in seconds; must be >= 1.
- CLEAR_S, 2, all-red clearance duration in seconds; must be >= 1.
- PED_S, 10, pedestrian walk duration in seconds; must be >= 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- green_sec_i  in  N_APPR*GREEN_W  packed green times in seconds; field k is bits [k*GREEN_W +: GREEN_W].
- ped_btn_i  in  N_APPR  pedestrian buttons, level, synchronous to clk.
- service_i  in  1  service-mode request, level.
- car_green_o  out  N_APPR  vehicle green lamp, one bit per approach.
- car_yellow_o  out  N_APPR  vehicle yellow lamp, one bit per approach.
- car_red_o  out  N_APPR  vehicle red lamp, one bit per approach.
- ped_green_o  out  N_APPR  pedestrian walk lamp, one bit per approach.
- ped_red_o  out  N_APPR  pedestrian don't-walk lamp, one bit per approach.
- active_o  out  $clog2(N_APPR)  index of the approach currently being served.
- ped_pend_o  out  N_APPR  latched pedestrian requests.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - FSM goes to CLEAR with active_o=0; prescaler, second counter and ped_pend_o all clear to 0.
  - Outputs: car_red_o and ped_red_o all ones; all green and yellow outputs 0.
  - Reset mid-phase aborts the phase immediately.
- Tick generation:
  - The prescaler counts 0..CLK_DIV-1; tick is asserted when the count is CLK_DIV-1.
  - The prescaler clears on every FSM state change, so a phase of S seconds lasts exactly S*CLK_DIV cycles.
- Second counter:
  - Loaded with the phase duration on phase entry; decrements on each tick.
  - The phase ends on the tick at which the counter equals 1.
- States:
  - CLEAR: all vehicle and pedestrian lamps red. Lasts CLEAR_S. Exit goes to GREEN for the next eligible approach.
  - GREEN: car_green_o[active] = 1. Lasts green_sec[active], sampled on entry; later changes to green_sec_i take effect on that approach's next turn. Exit goes to YELLOW.
  - YELLOW: car_yellow_o[active] = 1. Lasts YELLOW_S. Exit goes to PED if ped_pend[active], otherwise to CLEAR.
  - PED: ped_green_o[active] = 1 and every vehicle lamp red. Lasts PED_S. Exit goes to CLEAR.
  - SERVICE: see the service rules below.
- Outside their active bit, every approach shows car_red=1 and ped_red=1. Exactly one vehicle lamp is lit per approach in every non-service state.
- Next eligible approach:
  - Search from (active+1) mod N_APPR, wrapping, for the first approach with a non-zero green field. The search covers all N_APPR approaches including the current one, so if only the current approach is eligible it is served again.
  - The search is combinational on the cycle CLEAR ends.
  - If all green fields are 0, the FSM stays in CLEAR and reloads CLEAR_S. Pending pedestrian requests are still served: the first pending index found from active+1 goes to PED, then back to CLEAR.
- Pedestrian latch:
  - ped_pend[k] sets on ped_btn_i[k]=1 and clears on the cycle the FSM enters PED for k.
  - Set wins over clear, so a button held through PED entry stays pending.
- Service mode:
  - service_i=1 sampled in any state forces SERVICE on the next cycle.
  - In SERVICE: car_yellow_o toggles all-on/all-off every tick, starting on; car_green_o and car_red_o are 0; ped_red_o is all ones; ped_pend keeps latching.
  - When service_i falls, the FSM goes to CLEAR with active_o=N_APPR-1, so service resumes at approach 0.
- Outputs are registered. Lamp outputs change on the clock edge that the state changes.
- Simultaneous events: reset dominates service; service dominates a tick-driven phase end.

Decomposition:
- Package intersection_pkg holds:
  - the state enum {CLEAR, GREEN, YELLOW, PED, SERVICE};
  - localparams IDX_W=$clog2(N_APPR) and SEC_W = max(GREEN_W, $clog2(max(YELLOW_S, CLEAR_S, PED_S)+1)).
- One sub-module, sec_tick_gen: parameter CLK_DIV; ports clk, rst_n, clr_i, tick_o.
- The FSM, second counter, pedestrian latch and next-approach search stay in intersection_ctrl_n.

Test Plan (all scenarios use CLK_DIV=4, N_APPR=4, YELLOW_S=1, CLEAR_S=1, PED_S=2):
- Reset then green={3,2,4,1}, no buttons -> sequence CLEAR 4 cycles, G0 12, Y0 4, CLEAR 4, G1 8, ...; active_o runs 0,1,2,3,0.
- Green={3,0,2,0} -> approaches 1 and 3 never show green; active_o runs 0,2,0.
- Pulse ped_btn_i[2] for 1 cycle during G0 -> ped_pend_o[2] set; after Y2 a PED phase of 8 cycles with ped_green_o=4'b0100 and car_red_o=4'hF; ped_pend_o[2] clears on PED entry.
- Hold ped_btn_i[1] high through PED entry for approach 1 -> ped_pend_o[1] stays 1; PED repeats on the next approach-1 turn.
- service_i=1 mid-G2 -> next cycle car_yellow_o=4'hF, toggling every 4 cycles; drop service_i -> CLEAR 4 cycles, then G0.
- All green fields 0 with ped_pend_o[3]=1 -> CLEAR then PED3 then CLEAR repeating; no vehicle green ever.
- Assert rst_n=0 asynchronously mid-PED -> outputs go red immediately without waiting for a clock edge; ped_pend_o=0.

Source files
------------

// File: rtl/intersection_pkg.sv
// Shared types and sizing helpers for the N-approach intersection controller.
package intersection_pkg;

    typedef enum logic [2:0] {
        CLEAR,
        GREEN,
        YELLOW,
        PED,
        SERVICE
    } state_t;

    localparam int N_APPR_DEF   = 4;
    localparam int GREEN_W_DEF  = 8;
    localparam int YELLOW_S_DEF = 3;
    localparam int CLEAR_S_DEF  = 2;
    localparam int PED_S_DEF    = 10;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // The second counter must hold any green field as well as the fixed phase lengths.
    function automatic int sec_width(input int gw, input int ys, input int cs, input int ps);
        return max2(gw, $clog2(max2(ys, max2(cs, ps)) + 1));
    endfunction

    localparam int IDX_W = $clog2(N_APPR_DEF);
    localparam int SEC_W = sec_width(GREEN_W_DEF, YELLOW_S_DEF, CLEAR_S_DEF, PED_S_DEF);

endpackage

// File: rtl/sec_tick_gen.sv
// One-second tick prescaler; clr_i restarts the count so every phase begins on a whole second.
module sec_tick_gen
    import intersection_pkg::*;
#(
    parameter int CLK_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic tick_o
);

    localparam int W = $clog2(CLK_DIV);
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr_i || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign tick_o = (cnt == LAST);

endmodule

// File: rtl/intersection_ctrl_n.sv
// Round-robin N-approach traffic controller with pedestrian walk phase and flashing service mode.
module intersection_ctrl_n
    import intersection_pkg::*;
#(
    parameter int N_APPR   = N_APPR_DEF,
    parameter int CLK_DIV  = 1000,
    parameter int GREEN_W  = GREEN_W_DEF,
    parameter int YELLOW_S = YELLOW_S_DEF,
    parameter int CLEAR_S  = CLEAR_S_DEF,
    parameter int PED_S    = PED_S_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_APPR*GREEN_W-1:0]   green_sec_i,
    input  logic [N_APPR-1:0]           ped_btn_i,
    input  logic                        service_i,
    output logic [N_APPR-1:0]           car_green_o,
    output logic [N_APPR-1:0]           car_yellow_o,
    output logic [N_APPR-1:0]           car_red_o,
    output logic [N_APPR-1:0]           ped_green_o,
    output logic [N_APPR-1:0]           ped_red_o,
    output logic [$clog2(N_APPR)-1:0]   active_o,
    output logic [N_APPR-1:0]           ped_pend_o
);

    localparam int ACT_W = $clog2(N_APPR);
    localparam int CNT_W = sec_width(GREEN_W, YELLOW_S, CLEAR_S, PED_S);

    function automatic logic [ACT_W-1:0] wrap_add(input logic [ACT_W-1:0] a, input int i);
        int s;
        s = int'(a) + i;
        if (s >= N_APPR) s = s - N_APPR;
        return ACT_W'(s);
    endfunction

    state_t             state, state_nx;
    logic [ACT_W-1:0]   active_nx;
    logic [CNT_W-1:0]   sec_cnt, sec_nx;
    logic               flash, flash_nx;
    logic               first_pass;
    logic               tick, phase_end, state_chg, enter_ped;
    logic [N_APPR-1:0]  ped_pend_nx, sel_nx;

    logic [GREEN_W-1:0] green_f [N_APPR];
    logic [N_APPR-1:0]  green_nz;
    logic [ACT_W-1:0]   search_start, green_idx, ped_idx;
    logic               green_found, ped_found;

    logic [N_APPR-1:0]  car_green_nx, car_yellow_nx, car_red_nx, ped_green_nx, ped_red_nx;

    sec_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (state_chg),
        .tick_o (tick)
    );

    always_comb begin
        for (int k = 0; k < N_APPR; k++) begin
            green_f[k]  = green_sec_i[k*GREEN_W +: GREEN_W];
            green_nz[k] = |green_f[k];
        end
    end

    // The very first search after reset starts at approach 0 itself rather than after it.
    always_comb begin
        search_start = first_pass ? '0 : wrap_add(active_o, 1);
        green_found  = 1'b0;
        green_idx    = '0;
        ped_found    = 1'b0;
        ped_idx      = '0;
        for (int i = N_APPR - 1; i >= 0; i--) begin
            if (green_nz[wrap_add(search_start, i)]) begin
                green_found = 1'b1;
                green_idx   = wrap_add(search_start, i);
            end
            if (ped_pend_o[wrap_add(search_start, i)]) begin
                ped_found = 1'b1;
                ped_idx   = wrap_add(search_start, i);
            end
        end
    end

    // A zero count (only seen straight after reset) ends the phase just like a count of 1.
    always_comb begin
        state_nx  = state;
        active_nx = active_o;
        sec_nx    = sec_cnt;
        flash_nx  = flash;
        phase_end = tick && (sec_cnt <= CNT_W'(1));
        if (tick && !phase_end) sec_nx = sec_cnt - CNT_W'(1);

        if (service_i) begin
            state_nx = SERVICE;
            if (state != SERVICE) flash_nx = 1'b1;
            else if (tick)        flash_nx = ~flash;
        end else begin
            case (state)
                CLEAR: begin
                    if (phase_end) begin
                        if (green_found) begin
                            state_nx  = GREEN;
                            active_nx = green_idx;
                            sec_nx    = CNT_W'(green_f[green_idx]);
                        end else if (ped_found) begin
                            state_nx  = PED;
                            active_nx = ped_idx;
                            sec_nx    = CNT_W'(PED_S);
                        end else begin
                            sec_nx = CNT_W'(CLEAR_S);
                        end
                    end
                end
                GREEN: begin
                    if (phase_end) begin
                        state_nx = YELLOW;
                        sec_nx   = CNT_W'(YELLOW_S);
                    end
                end
                YELLOW: begin
                    if (phase_end) begin
                        if (ped_pend_o[active_o]) begin
                            state_nx = PED;
                            sec_nx   = CNT_W'(PED_S);
                        end else begin
                            state_nx = CLEAR;
                            sec_nx   = CNT_W'(CLEAR_S);
                        end
                    end
                end
                PED: begin
                    if (phase_end) begin
                        state_nx = CLEAR;
                        sec_nx   = CNT_W'(CLEAR_S);
                    end
                end
                SERVICE: begin
                    state_nx  = CLEAR;
                    active_nx = ACT_W'(N_APPR - 1);
                    sec_nx    = CNT_W'(CLEAR_S);
                    flash_nx  = 1'b0;
                end
                default: begin
                    state_nx = CLEAR;
                    sec_nx   = CNT_W'(CLEAR_S);
                end
            endcase
        end
    end

    assign state_chg = (state_nx != state);
    assign sel_nx    = N_APPR'(1) << active_nx;
    assign enter_ped = (state_nx == PED) && (state != PED);

    // Button set wins over the entry clear so a held button stays pending.
    assign ped_pend_nx = (ped_pend_o & ~(enter_ped ? sel_nx : '0)) | ped_btn_i;

    always_comb begin
        car_green_nx  = '0;
        car_yellow_nx = '0;
        car_red_nx    = '1;
        ped_green_nx  = '0;
        ped_red_nx    = '1;
        case (state_nx)
            GREEN: begin
                car_green_nx = sel_nx;
                car_red_nx   = ~sel_nx;
            end
            YELLOW: begin
                car_yellow_nx = sel_nx;
                car_red_nx    = ~sel_nx;
            end
            PED: begin
                ped_green_nx = sel_nx;
                ped_red_nx   = ~sel_nx;
            end
            SERVICE: begin
                car_red_nx    = '0;
                car_yellow_nx = flash_nx ? '1 : '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= CLEAR;
            active_o     <= '0;
            sec_cnt      <= '0;
            flash        <= 1'b0;
            first_pass   <= 1'b1;
            ped_pend_o   <= '0;
            car_green_o  <= '0;
            car_yellow_o <= '0;
            car_red_o    <= '1;
            ped_green_o  <= '0;
            ped_red_o    <= '1;
        end else begin
            state        <= state_nx;
            active_o     <= active_nx;
            sec_cnt      <= sec_nx;
            flash        <= flash_nx;
            if (state_chg) first_pass <= 1'b0;
            ped_pend_o   <= ped_pend_nx;
            car_green_o  <= car_green_nx;
            car_yellow_o <= car_yellow_nx;
            car_red_o    <= car_red_nx;
            ped_green_o  <= ped_green_nx;
            ped_red_o    <= ped_red_nx;
        end
    end

endmodule

// File: tb/tb_intersection_ctrl_n.sv
// Directed bench for intersection_ctrl_n: CLK_DIV=4, 4 approaches, 1 s yellow/clear, 2 s walk.
module tb_intersection_ctrl_n;
    import intersection_pkg::*;

    localparam int N  = 4;
    localparam int GW = 8;
    localparam int K_CLEAR = 0, K_GREEN = 1, K_YELLOW = 2, K_PED = 3, K_SVC_ON = 4, K_SVC_OFF = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N*GW-1:0]   green_sec;
    logic [N-1:0]      ped_btn;
    logic              service;
    logic [N-1:0]      car_green, car_yellow, car_red, ped_green, ped_red, ped_pend;
    logic [IDX_W-1:0]  active;
    logic [21:0]       lamps;
    int                checks = 0;
    int                errors = 0;

    always #5 clk = ~clk;

    intersection_ctrl_n #(
        .N_APPR(N), .CLK_DIV(4), .GREEN_W(GW), .YELLOW_S(1), .CLEAR_S(1), .PED_S(2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .green_sec_i  (green_sec),
        .ped_btn_i    (ped_btn),
        .service_i    (service),
        .car_green_o  (car_green),
        .car_yellow_o (car_yellow),
        .car_red_o    (car_red),
        .ped_green_o  (ped_green),
        .ped_red_o    (ped_red),
        .active_o     (active),
        .ped_pend_o   (ped_pend)
    );

    assign lamps = {car_green, car_yellow, car_red, ped_green, ped_red, active};

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [21:0] exp_lamps(input int kind, input int a);
        logic [3:0] sel, g, y, r, pg, pr;
        sel = 4'b0001 << a;
        g = 4'h0; y = 4'h0; r = 4'hF; pg = 4'h0; pr = 4'hF;
        case (kind)
            K_GREEN:   begin g = sel;  r = ~sel;  end
            K_YELLOW:  begin y = sel;  r = ~sel;  end
            K_PED:     begin pg = sel; pr = ~sel; end
            K_SVC_ON:  begin y = 4'hF; r = 4'h0;  end
            K_SVC_OFF: begin r = 4'h0;           end
            default: ;
        endcase
        return {g, y, r, pg, pr, 2'(a)};
    endfunction

    task automatic applyStimulus(input logic [31:0] g, input logic [3:0] b, input logic s);
        green_sec = g;
        ped_btn   = b;
        service   = s;
    endtask

    task automatic restart();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Checks the lamp word on n consecutive falling edges, starting at the current one.
    task automatic expect_phase(input string tag, input int kind, input int a, input int n);
        for (int i = 0; i < n; i++) begin
            checkOutput(tag, 32'(lamps), 32'(exp_lamps(kind, a)));
            @(negedge clk);
        end
    endtask

    initial begin
        applyStimulus(32'h0, 4'h0, 1'b0);
        #12;
        checkOutput("reset_lamps", 32'(lamps), 32'(exp_lamps(K_CLEAR, 0)));
        checkOutput("reset_pend", 32'(ped_pend), 32'h0);

        applyStimulus(32'h01040203, 4'h0, 1'b0);
        restart();
        expect_phase("s1_clr0", K_CLEAR, 0, 4);
        expect_phase("s1_g0", K_GREEN, 0, 12);
        expect_phase("s1_y0", K_YELLOW, 0, 4);
        expect_phase("s1_clr0b", K_CLEAR, 0, 4);
        expect_phase("s1_g1", K_GREEN, 1, 8);
        expect_phase("s1_y1", K_YELLOW, 1, 4);
        expect_phase("s1_clr1", K_CLEAR, 1, 4);
        expect_phase("s1_g2", K_GREEN, 2, 16);
        expect_phase("s1_y2", K_YELLOW, 2, 4);
        expect_phase("s1_clr2", K_CLEAR, 2, 4);
        expect_phase("s1_g3", K_GREEN, 3, 4);
        expect_phase("s1_y3", K_YELLOW, 3, 4);
        expect_phase("s1_clr3", K_CLEAR, 3, 4);
        expect_phase("s1_g0wrap", K_GREEN, 0, 12);

        applyStimulus(32'h00020003, 4'h0, 1'b0);
        restart();
        expect_phase("s2_clr0", K_CLEAR, 0, 4);
        expect_phase("s2_g0", K_GREEN, 0, 12);
        expect_phase("s2_y0", K_YELLOW, 0, 4);
        expect_phase("s2_clr0b", K_CLEAR, 0, 4);
        expect_phase("s2_g2", K_GREEN, 2, 8);
        expect_phase("s2_y2", K_YELLOW, 2, 4);
        expect_phase("s2_clr2", K_CLEAR, 2, 4);
        expect_phase("s2_g0wrap", K_GREEN, 0, 12);

        applyStimulus(32'h01040203, 4'h0, 1'b0);
        restart();
        expect_phase("s3_clr0", K_CLEAR, 0, 4);
        expect_phase("s3_g0a", K_GREEN, 0, 2);
        ped_btn = 4'b0100;
        expect_phase("s3_g0b", K_GREEN, 0, 1);
        ped_btn = 4'b0000;
        checkOutput("s3_pend_set", 32'(ped_pend), 32'h4);
        expect_phase("s3_g0c", K_GREEN, 0, 9);
        expect_phase("s3_y0", K_YELLOW, 0, 4);
        expect_phase("s3_clr0", K_CLEAR, 0, 4);
        expect_phase("s3_g1", K_GREEN, 1, 8);
        expect_phase("s3_y1", K_YELLOW, 1, 4);
        expect_phase("s3_clr1", K_CLEAR, 1, 4);
        expect_phase("s3_g2", K_GREEN, 2, 16);
        checkOutput("s3_pend_held", 32'(ped_pend), 32'h4);
        expect_phase("s3_y2", K_YELLOW, 2, 4);
        expect_phase("s3_ped2a", K_PED, 2, 1);
        checkOutput("s3_pend_clr", 32'(ped_pend), 32'h0);
        expect_phase("s3_ped2b", K_PED, 2, 7);
        expect_phase("s3_clr2", K_CLEAR, 2, 4);
        expect_phase("s3_g3", K_GREEN, 3, 4);

        applyStimulus(32'h01040203, 4'b0010, 1'b0);
        restart();
        expect_phase("s4_clr0", K_CLEAR, 0, 4);
        expect_phase("s4_g0", K_GREEN, 0, 12);
        expect_phase("s4_y0", K_YELLOW, 0, 4);
        expect_phase("s4_clr0b", K_CLEAR, 0, 4);
        expect_phase("s4_g1", K_GREEN, 1, 8);
        expect_phase("s4_y1", K_YELLOW, 1, 4);
        expect_phase("s4_ped1a", K_PED, 1, 1);
        checkOutput("s4_pend_kept", 32'(ped_pend), 32'h2);
        ped_btn = 4'b0000;
        expect_phase("s4_ped1b", K_PED, 1, 7);
        checkOutput("s4_pend_latched", 32'(ped_pend), 32'h2);
        expect_phase("s4_clr1", K_CLEAR, 1, 4);
        expect_phase("s4_g2", K_GREEN, 2, 16);
        expect_phase("s4_y2", K_YELLOW, 2, 4);
        expect_phase("s4_clr2", K_CLEAR, 2, 4);
        expect_phase("s4_g3", K_GREEN, 3, 4);
        expect_phase("s4_y3", K_YELLOW, 3, 4);
        expect_phase("s4_clr3", K_CLEAR, 3, 4);
        expect_phase("s4_g0b", K_GREEN, 0, 12);
        expect_phase("s4_y0b", K_YELLOW, 0, 4);
        expect_phase("s4_clr0c", K_CLEAR, 0, 4);
        expect_phase("s4_g1b", K_GREEN, 1, 8);
        expect_phase("s4_y1b", K_YELLOW, 1, 4);
        expect_phase("s4_ped1c", K_PED, 1, 2);
        checkOutput("s4_pend_clr", 32'(ped_pend), 32'h0);
        expect_phase("s4_ped1d", K_PED, 1, 6);
        expect_phase("s4_clr1b", K_CLEAR, 1, 4);

        applyStimulus(32'h01040203, 4'h0, 1'b0);
        restart();
        expect_phase("s5_clr0", K_CLEAR, 0, 4);
        expect_phase("s5_g0", K_GREEN, 0, 12);
        expect_phase("s5_y0", K_YELLOW, 0, 4);
        expect_phase("s5_clr0b", K_CLEAR, 0, 4);
        expect_phase("s5_g1", K_GREEN, 1, 8);
        expect_phase("s5_y1", K_YELLOW, 1, 4);
        expect_phase("s5_clr1", K_CLEAR, 1, 4);
        expect_phase("s5_g2a", K_GREEN, 2, 5);
        service = 1'b1;
        expect_phase("s5_g2b", K_GREEN, 2, 1);
        expect_phase("s5_svc_on", K_SVC_ON, 2, 4);
        expect_phase("s5_svc_off", K_SVC_OFF, 2, 4);
        expect_phase("s5_svc_on2", K_SVC_ON, 2, 2);
        service = 1'b0;
        expect_phase("s5_svc_on3", K_SVC_ON, 2, 1);
        expect_phase("s5_clr3", K_CLEAR, 3, 4);
        expect_phase("s5_g0", K_GREEN, 0, 12);

        applyStimulus(32'h0, 4'b1000, 1'b0);
        restart();
        expect_phase("s6_clr0", K_CLEAR, 0, 4);
        expect_phase("s6_ped3", K_PED, 3, 8);
        checkOutput("s6_pend_held", 32'(ped_pend), 32'h8);
        expect_phase("s6_clr3", K_CLEAR, 3, 4);
        expect_phase("s6_ped3b", K_PED, 3, 3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("s6_async_lamps", 32'(lamps), 32'(exp_lamps(K_CLEAR, 0)));
        checkOutput("s6_async_pend", 32'(ped_pend), 32'h0);

        applyStimulus(32'h0, 4'h0, 1'b0);
        restart();
        expect_phase("s7_idle_clr", K_CLEAR, 0, 12);
        checkOutput("s7_pend", 32'(ped_pend), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
